// File: rtl/exe_mem_pipe_stage_if.sv
// Valid/ready payload bundle between the EXE datapath, the EXE->MEM stage and data memory.
// The producer uses the master modport and the consumer uses the slave modport.
interface exe_mem_pipe_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] br_addr;
   logic [DATA_W-1:0] rt;
   logic [REG_AW-1:0] dst_reg;
   logic [REG_AW-1:0] rd;
   logic              zero;
   logic [5:0]        ctrl;

   modport master (
      output valid, result, br_addr, rt, dst_reg, rd, zero, ctrl,
      input  ready
   );

   modport slave (
      input  valid, result, br_addr, rt, dst_reg, rd, zero, ctrl,
      output ready
   );
endinterface

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline register with a 2-entry skid buffer (main + skid), flush to bubble,
// and registered beq/bne branch resolution presented as o_mem_pc_src.
module exe_mem_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   exe_mem_pipe_stage_if.slave   i_exe,
   exe_mem_pipe_stage_if.master  o_mem,
   output logic                  o_mem_pc_src
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] br_addr;
      logic [DATA_W-1:0] rt;
      logic [REG_AW-1:0] dst_reg;
      logic [REG_AW-1:0] rd;
      logic              zero;
      logic [5:0]        ctrl;
   } payload_t;

   // ST_ONE: only main holds an entry; ST_FULL: main and skid both hold entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t   r_state;
   state_t   w_state_nxt;
   payload_t r_main;
   payload_t r_skid;
   payload_t w_in;
   logic     w_accept;
   logic     w_retire;
   logic     w_ld_main_in;
   logic     w_ld_main_skid;
   logic     w_ld_skid;
   logic     w_out_valid;

   always_comb begin
      w_in.result  = i_exe.result;
      w_in.br_addr = i_exe.br_addr;
      w_in.rt      = i_exe.rt;
      w_in.dst_reg = i_exe.dst_reg;
      w_in.rd      = i_exe.rd;
      w_in.zero    = i_exe.zero;
      w_in.ctrl    = i_exe.ctrl;
   end

   assign w_out_valid = (r_state != ST_EMPTY);
   assign i_exe.ready = (r_state != ST_FULL);
   assign w_accept    = i_exe.valid & i_exe.ready;
   assign w_retire    = w_out_valid & o_mem.ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_ld_main_in = 1'b1;
               w_state_nxt  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_retire && w_accept) begin
               w_ld_main_in = 1'b1;
            end else if (w_retire) begin
               w_state_nxt = ST_EMPTY;
            end else if (w_accept) begin
               w_ld_skid   = 1'b1;
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so the skid entry drains before any new input.
            if (w_retire) begin
               w_ld_main_skid = 1'b1;
               w_state_nxt    = ST_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
      if (i_flush) begin
         w_state_nxt    = ST_EMPTY;
         w_ld_main_in   = 1'b0;
         w_ld_main_skid = 1'b0;
         w_ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_main <= w_in;
         end else if (w_ld_main_skid) begin
            r_main <= r_skid;
         end
         if (w_ld_skid) begin
            r_skid <= w_in;
         end
      end
   end

   always_comb begin
      o_mem.valid   = w_out_valid;
      o_mem.result  = r_main.result;
      o_mem.br_addr = r_main.br_addr;
      o_mem.rt      = r_main.rt;
      o_mem.dst_reg = r_main.dst_reg;
      o_mem.rd      = r_main.rd;
      o_mem.zero    = r_main.zero;
      o_mem.ctrl    = w_out_valid ? r_main.ctrl : '0;
   end

   // ctrl[5] = beq, ctrl[4] = bne
   assign o_mem_pc_src = w_out_valid &
                         ((r_main.ctrl[5] & r_main.zero) | (r_main.ctrl[4] & ~r_main.zero));

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Directed self-checking bench for exe_mem_pipe_stage: reset, latency, skid back-pressure,
// branch resolution, flush, reset while full and an in-order stream under random stalls.
module tb_exe_mem_pipe_stage;

   logic clk;
   logic reset;
   logic flush;
   logic pc_src;
   int   n_checks;
   int   n_pass;

   exe_mem_pipe_stage_if #(.DATA_W(32), .REG_AW(5)) in_if ();
   exe_mem_pipe_stage_if #(.DATA_W(32), .REG_AW(5)) out_if ();

   exe_mem_pipe_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_flush      (flush),
      .i_exe        (in_if),
      .o_mem        (out_if),
      .o_mem_pc_src (pc_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [5:0] ctrl,
                        input logic z);
      in_if.valid   = v;
      in_if.result  = res;
      in_if.br_addr = res + 32'h1000;
      in_if.rt      = ~res;
      in_if.dst_reg = res[4:0];
      in_if.rd      = res[9:5];
      in_if.zero    = z;
      in_if.ctrl    = ctrl;
   endtask

   task automatic test_reset;
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      out_if.ready = 1'b1;
      flush = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++;
      if (out_if.valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_if.valid);
      else n_pass++;
      n_checks++;
      if (in_if.ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_if.ready);
      else n_pass++;
      n_checks++;
      if (out_if.result !== 32'h0) $display("FAIL reset_result: got %h expected 0", out_if.result);
      else n_pass++;
      n_checks++;
      if (out_if.ctrl !== 6'h0 || pc_src !== 1'b0)
         $display("FAIL reset_ctrl: got ctrl=%h pc_src=%b expected 00/0", out_if.ctrl, pc_src);
      else n_pass++;
   endtask

   task automatic test_latency;
      out_if.ready = 1'b1;
      drive(1'b1, 32'h0000_0010, 6'b000001, 1'b0);
      tick();
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      n_checks++;
      if (out_if.valid !== 1'b1 || out_if.result !== 32'h10)
         $display("FAIL latency_out: got valid=%b result=%h expected 1/00000010",
                  out_if.valid, out_if.result);
      else n_pass++;
      n_checks++;
      if (out_if.br_addr !== 32'h1010 || out_if.rt !== 32'hFFFF_FFEF || out_if.dst_reg !== 5'h10)
         $display("FAIL latency_payload: got br=%h rt=%h dst=%h expected 00001010/ffffffef/10",
                  out_if.br_addr, out_if.rt, out_if.dst_reg);
      else n_pass++;
      n_checks++;
      if (in_if.ready !== 1'b1) $display("FAIL latency_in_ready: got %b expected 1", in_if.ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_if.valid !== 1'b0) $display("FAIL latency_drain: got %b expected 0", out_if.valid);
      else n_pass++;
   endtask

   task automatic test_skid;
      out_if.ready = 1'b0;
      drive(1'b1, 32'hA, 6'b000010, 1'b0);
      tick();
      n_checks++;
      if (out_if.result !== 32'hA || in_if.ready !== 1'b1)
         $display("FAIL skid_a: got result=%h in_ready=%b expected a/1", out_if.result, in_if.ready);
      else n_pass++;
      drive(1'b1, 32'hB, 6'b000100, 1'b0);
      tick();
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      n_checks++;
      if (out_if.result !== 32'hA || in_if.ready !== 1'b0 || out_if.ctrl !== 6'b000010)
         $display("FAIL skid_full: got result=%h in_ready=%b ctrl=%h expected a/0/02",
                  out_if.result, in_if.ready, out_if.ctrl);
      else n_pass++;
      tick();
      n_checks++;
      if (out_if.result !== 32'hA || in_if.ready !== 1'b0)
         $display("FAIL skid_hold: got result=%h in_ready=%b expected a/0", out_if.result, in_if.ready);
      else n_pass++;
      out_if.ready = 1'b1;
      tick();
      n_checks++;
      if (out_if.valid !== 1'b1 || out_if.result !== 32'hB || out_if.ctrl !== 6'b000100)
         $display("FAIL skid_b: got valid=%b result=%h ctrl=%h expected 1/b/04",
                  out_if.valid, out_if.result, out_if.ctrl);
      else n_pass++;
      n_checks++;
      if (in_if.ready !== 1'b1) $display("FAIL skid_in_ready: got %b expected 1", in_if.ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_if.valid !== 1'b0) $display("FAIL skid_empty: got %b expected 0", out_if.valid);
      else n_pass++;
   endtask

   task automatic test_branch;
      logic [5:0] ctrl_v [4] = '{6'b100000, 6'b010000, 6'b010000, 6'b100000};
      logic       zero_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       exp_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      out_if.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h40 + i, ctrl_v[i], zero_v[i]);
         tick();
         n_checks++;
         if (pc_src !== exp_v[i] || out_if.zero !== zero_v[i] || out_if.ctrl !== ctrl_v[i])
            $display("FAIL branch_%0d: got pc_src=%b zero=%b ctrl=%h expected %b/%b/%h",
                     i, pc_src, out_if.zero, out_if.ctrl, exp_v[i], zero_v[i], ctrl_v[i]);
         else n_pass++;
      end
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      tick();
      n_checks++;
      if (pc_src !== 1'b0) $display("FAIL branch_idle: got %b expected 0", pc_src);
      else n_pass++;
   endtask

   task automatic test_flush;
      out_if.ready = 1'b0;
      drive(1'b1, 32'hA, 6'b100001, 1'b1);
      tick();
      drive(1'b1, 32'hB, 6'b010001, 1'b0);
      tick();
      drive(1'b1, 32'hC, 6'b100001, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      n_checks++;
      if (out_if.valid !== 1'b0 || out_if.ctrl !== 6'h0 || pc_src !== 1'b0)
         $display("FAIL flush_bubble: got valid=%b ctrl=%h pc_src=%b expected 0/00/0",
                  out_if.valid, out_if.ctrl, pc_src);
      else n_pass++;
      n_checks++;
      if (in_if.ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", in_if.ready);
      else n_pass++;
      out_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (out_if.valid !== 1'b0)
            $display("FAIL flush_leak_%0d: got valid=%b result=%h expected valid 0",
                     i, out_if.valid, out_if.result);
         else n_pass++;
      end
      drive(1'b1, 32'hD, 6'b000001, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      n_checks++;
      if (out_if.valid !== 1'b0)
         $display("FAIL flush_input: got valid=%b result=%h expected valid 0",
                  out_if.valid, out_if.result);
      else n_pass++;
   endtask

   task automatic test_reset_full;
      out_if.ready = 1'b0;
      drive(1'b1, 32'h5A5A_0011, 6'b100011, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0022, 6'b000101, 1'b0);
      tick();
      drive(1'b1, 32'h0000_0033, 6'b000001, 1'b0);
      flush = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      n_checks++;
      if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1)
         $display("FAIL rstfull_flags: got valid=%b in_ready=%b expected 0/1",
                  out_if.valid, in_if.ready);
      else n_pass++;
      n_checks++;
      if ({out_if.result, out_if.br_addr, out_if.rt} !== 96'h0 ||
          {out_if.dst_reg, out_if.rd, out_if.zero, out_if.ctrl, pc_src} !== 18'h0)
         $display("FAIL rstfull_outputs: got result=%h br=%h rt=%h dst=%h rd=%h z=%b ctrl=%h pc=%b expected all 0",
                  out_if.result, out_if.br_addr, out_if.rt, out_if.dst_reg, out_if.rd,
                  out_if.zero, out_if.ctrl, pc_src);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int   sent;
      int   got;
      int   cyc;
      logic acc;
      logic ret;
      sent = 0;
      got  = 0;
      cyc  = 0;
      while ((sent < 16 || got < 16) && cyc < 400) begin
         drive(sent < 16, 32'h100 + sent, 6'b000001, 1'b0);
         in_if.dst_reg = sent[4:0];
         out_if.ready  = 1'($urandom_range(0, 1));
         #1;
         acc = in_if.valid & in_if.ready;
         ret = out_if.valid & out_if.ready;
         if (ret) begin
            n_checks++;
            if (got >= 16 || out_if.result !== 32'h100 + got || out_if.dst_reg !== got[4:0])
               $display("FAIL stream_word_%0d: got result=%h dst=%h expected %h/%h",
                        got, out_if.result, out_if.dst_reg, 32'h100 + got, got[4:0]);
            else n_pass++;
            got++;
         end
         tick();
         if (acc) sent++;
         cyc++;
      end
      n_checks++;
      if (sent !== 16 || got !== 16)
         $display("FAIL stream_count: got sent=%0d received=%0d cycles=%0d expected 16/16",
                  sent, got, cyc);
      else n_pass++;
      drive(1'b0, 32'h0, 6'h0, 1'b0);
      out_if.ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (out_if.valid !== 1'b0)
         $display("FAIL stream_extra: got valid=%b result=%h expected valid 0",
                  out_if.valid, out_if.result);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      flush    = 1'b0;
      test_reset();
      test_latency();
      test_skid();
      test_branch();
      test_flush();
      test_reset_full();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
